// File: rtl/instruction_fetch.sv
// Fetch front end: PC register, one-deep request pipeline to a
// synchronous instruction memory, and a small {instr, pc} FIFO to decode.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            decode_ready,
  output logic            instruction_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instruction_pc,
  output logic [XLEN-1:0] instruction_next_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   occupancy;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] head_pc;

  assign redirect_base = redirect_pc & ~XLEN'(3);
  assign occupancy = count_q + CW'(inflight_valid_q);

  // Issue looks only at current occupancy; a same-cycle pop does not count
  assign issue = !reset && !redirect
              && (occupancy < CW'(DEPTH));
  assign push  = inflight_valid_q && !redirect;
  assign pop   = instruction_valid && decode_ready
              && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_base;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d       = fetch_pc_q + XLEN'(4);
        inflight_valid_d = 1'b1;
        inflight_pc_d    = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage needs no reset: empty entries are masked at the outputs
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign instruction_valid = (count_q != '0);
  assign head_pc = pc_mem_q[rd_ptr_q];

  assign instruction = instruction_valid
                     ? instr_mem_q[rd_ptr_q] : '0;
  assign instruction_pc = instruction_valid
                        ? head_pc : '0;
  assign instruction_next_pc = instruction_valid
                             ? head_pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, backpressure,
// redirects, PC wrap and reset mid-operation.
module tb_instruction_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        decode_ready;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic [31:0] instruction_next_pc;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .decode_ready(decode_ready),
    .instruction_valid(instruction_valid),
    .instruction(instruction),
    .instruction_pc(instruction_pc),
    .instruction_next_pc(instruction_next_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_q;
  always @(posedge clk)
    if (imem_req) mem_q <= imem_addr ^ MASK;
  assign imem_rdata = mem_q;

  // The FIFO must never be full when a response is captured
  always @(negedge clk) begin
    #2;
    if (!reset && !redirect && dut.inflight_valid_q
        && dut.count_q == DEPTH) begin
      errors++;
      $display("FAIL push_when_full count=%0d limit=%0d",
               dut.count_q, DEPTH);
    end
  end

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0;
    redirect_pc = '0; decode_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect = 1'b0;
    redirect_pc = '0; decode_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b exp 0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rst_addr got %h exp 100", imem_addr);
    end
    checks++;
    if ({instruction_valid, instruction, instruction_pc,
         instruction_next_pc} !== '0) begin
      errors++;
      $display("FAIL rst_outs got %b %h %h %h exp zeros",
               instruction_valid, instruction,
               instruction_pc, instruction_next_pc);
    end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL stream_c0 got req=%b addr=%h exp 1 100",
               imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b0
        || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL stream_c1 got v=%b addr=%h exp 0 104",
               instruction_valid, imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      @(negedge clk); #1;
      pc = 32'h100 + 32'(4 * k);
      checks++;
      if (instruction_valid !== 1'b1
          || instruction_pc !== pc
          || instruction !== (pc ^ MASK)
          || instruction_next_pc !== pc + 32'd4) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h i=%h np=%h exp pc=%h",
                 k, instruction_valid, instruction_pc,
                 instruction, instruction_next_pc, pc);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (imem_req !== 1'b1
          || imem_addr !== 32'h100 + 32'(4 * c)) begin
        errors++;
        $display("FAIL bp_req_c%0d got req=%b addr=%h",
                 c, imem_req, imem_addr);
      end
    end
    for (int c = 4; c < 7; c++) begin
      @(negedge clk); #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h110) begin
        errors++;
        $display("FAIL bp_stall_c%0d got req=%b addr=%h exp 0 110",
                 c, imem_req, imem_addr);
      end
    end
    checks++;
    if (instruction_valid !== 1'b1
        || instruction_pc !== 32'h100) begin
      errors++;
      $display("FAIL bp_head got v=%b pc=%h exp 1 100",
               instruction_valid, instruction_pc);
    end
    @(negedge clk);
    decode_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'h100 + 32'(4 * k);
      checks++;
      if (instruction_valid !== 1'b1
          || instruction_pc !== pc
          || instruction !== (pc ^ MASK)) begin
        errors++;
        $display("FAIL bp_drain_%0d got v=%b pc=%h i=%h exp pc=%h",
                 k, instruction_valid, instruction_pc,
                 instruction, pc);
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin
          errors++;
          $display("FAIL bp_resume got req=%b addr=%h exp 1 110",
                   imem_req, imem_addr);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instruction_pc !== 32'h108) begin
      errors++;
      $display("FAIL redir_cycle got req=%b pc=%h exp 0 108",
               imem_req, instruction_pc);
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if (instruction_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL redir_r1 got v=%b req=%b addr=%h exp 0 1 2000",
               instruction_valid, imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_r2 got v=%b exp 0",
               instruction_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b1
        || instruction_pc !== 32'h2000
        || instruction !== 32'hA5A5_2000
        || instruction_next_pc !== 32'h2004) begin
      errors++;
      $display("FAIL redir_r3 got v=%b pc=%h i=%h np=%h exp 2000",
               instruction_valid, instruction_pc,
               instruction, instruction_next_pc);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_pc !== 32'h2004) begin
      errors++;
      $display("FAIL redir_r4 got pc=%h exp 2004", instruction_pc);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    #1;
    @(negedge clk);
    redirect_pc = 32'h400;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got req=%b v=%b exp 0 0",
               imem_req, instruction_valid);
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      errors++;
      $display("FAIL b2b_req got req=%b addr=%h exp 1 400",
               imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got v=%b pc=%h exp 0",
               instruction_valid, instruction_pc);
    end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pc;
      @(negedge clk); #1;
      pc = 32'h400 + 32'(4 * k);
      checks++;
      if (instruction_valid !== 1'b1
          || instruction_pc !== pc) begin
        errors++;
        $display("FAIL b2b_pc_%0d got v=%b pc=%h exp %h",
                 k, instruction_valid, instruction_pc, pc);
      end
    end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (instruction_valid !== 1'b1
          || instruction_pc !== exp_pc[k]
          || instruction !== (exp_pc[k] ^ MASK)
          || instruction_next_pc !== exp_pc[k] + 32'd4) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h np=%h exp pc=%h",
                 k, instruction_valid, instruction_pc,
                 instruction_next_pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || instruction_pc !== 32'h100) begin
      errors++;
      $display("FAIL mid_pre got req=%b pc=%h exp 0 100",
               imem_req, instruction_pc);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({imem_req, instruction_valid, instruction,
         instruction_pc, instruction_next_pc} !== '0
        || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL mid_zero got req=%b v=%b pc=%h addr=%h",
               imem_req, instruction_valid,
               instruction_pc, imem_addr);
    end
    reset = 1'b0;
    decode_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL mid_c0 got req=%b addr=%h exp 1 100",
               imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_c1 got v=%b pc=%h exp 0",
               instruction_valid, instruction_pc);
    end
    @(negedge clk); #1;
    checks++;
    if (instruction_valid !== 1'b1
        || instruction_pc !== 32'h100
        || instruction !== 32'hA5A5_0100) begin
      errors++;
      $display("FAIL mid_c2 got v=%b pc=%h i=%h exp 1 100",
               instruction_valid, instruction_pc, instruction);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
